// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART controller: state encodings, op/select codes
// and the memory-mapped register addresses used by the memory stage.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_LOW   = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_LOW   = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_WR_WAIT  = 3'd5,
      ST_DONE     = 3'd6
   } state_t;

   localparam logic RAM_OP_RD = 1'b0;
   localparam logic RAM_OP_WR = 1'b1;

   localparam logic SEL_DATA = 1'b0;
   localparam logic SEL_STAT = 1'b1;

   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

   // Status word: bit 1 = RX byte waiting, bit 0 = transmitter fully idle.
   function automatic logic [15:0] status_word(input logic dr, input logic tbre,
                                               input logic tsre);
      return {14'b0, dr, tbre & tsre};
   endfunction

endpackage

// File: rtl/uart_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   // NOTE: non-blocking assignments make the two flops a true shift chain;
   // blocking here would collapse them into one stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-stage bridge to an external UART: sequences rdn/wrn strobes and the
// shared data bus, reports status, and stalls the pipeline until done.
module uart_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int RD_LOW_CYC = 2,
   parameter int WR_LOW_CYC = 2
) (
   input  logic        clk_50MHz,
   input  logic        rst,
   input  logic        req,
   input  logic        op,
   input  logic        sel,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        done,
   output logic        stall,
   input  logic [7:0]  bus_i,
   output logic [7:0]  bus_o,
   output logic        bus_oe,
   output logic        rdn,
   output logic        wrn,
   input  logic        data_ready,
   input  logic        tbre,
   input  logic        tsre
);

   localparam logic [7:0] RD_LAST = 8'(RD_LOW_CYC - 1);
   localparam logic [7:0] WR_LAST = 8'(WR_LOW_CYC - 1);

   logic dr_s, tbre_s, tsre_s;

   sync2 u_sync_dr   (.clk_i(clk_50MHz), .rst_i(rst), .d_i(data_ready), .q_o(dr_s));
   sync2 u_sync_tbre (.clk_i(clk_50MHz), .rst_i(rst), .d_i(tbre),       .q_o(tbre_s));
   sync2 u_sync_tsre (.clk_i(clk_50MHz), .rst_i(rst), .d_i(tsre),       .q_o(tsre_s));

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        tbre_seen_q;
   logic [15:0] rdata_q;
   logic [7:0]  bus_o_q;
   logic        bus_oe_q, rdn_q, wrn_q, done_q;

   logic unused_wdata_hi;
   assign unused_wdata_hi = ^wdata[15:8];

   // NOTE: every register, including the captured read data, is cleared by the
   // async reset so an aborted access leaves no strobe or stale result behind.
   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tbre_seen_q <= 1'b0;
         rdata_q     <= '0;
         bus_o_q     <= '0;
         bus_oe_q    <= 1'b0;
         rdn_q       <= 1'b1;
         wrn_q       <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req) begin
                  cnt_q       <= '0;
                  tbre_seen_q <= 1'b0;
                  rdata_q     <= '0;
                  if (sel == SEL_STAT) begin
                     if (op == RAM_OP_RD) rdata_q <= status_word(dr_s, tbre_s, tsre_s);
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else if (op == RAM_OP_WR) begin
                     bus_o_q  <= wdata[7:0];
                     bus_oe_q <= 1'b1;
                     state_q  <= ST_WR_SETUP;
                  end else if (dr_s) begin
                     rdn_q   <= 1'b0;
                     state_q <= ST_RD_LOW;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RD_LOW: begin
               if (cnt_q == RD_LAST) begin
                  rdn_q   <= 1'b1;
                  rdata_q <= {8'h00, bus_i};
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_WR_SETUP: begin
               wrn_q   <= 1'b0;
               state_q <= ST_WR_LOW;
            end
            ST_WR_LOW: begin
               if (cnt_q == WR_LAST) begin
                  wrn_q   <= 1'b1;
                  state_q <= ST_WR_HOLD;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_WR_HOLD: begin
               bus_oe_q <= 1'b0;
               state_q  <= ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
               // Buffer must drain before the shifter; both may show up together.
               if ((tbre_seen_q || tbre_s) && tsre_s) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else if (tbre_s) begin
                  tbre_seen_q <= 1'b1;
               end
            end
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign rdata  = rdata_q;
   assign done   = done_q;
   assign stall  = req & ~done_q;
   assign bus_o  = bus_o_q;
   assign bus_oe = bus_oe_q;
   assign rdn    = rdn_q;
   assign wrn    = wrn_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: status/data reads, data write handshake,
// mid-access reset and back-to-back requests.
module tb_uart_ctrl;

   logic        clk_50MHz = 1'b0;
   logic        rst;
   logic        req, op, sel;
   logic [15:0] wdata, rdata;
   logic        done, stall;
   logic [7:0]  bus_i, bus_o;
   logic        bus_oe, rdn, wrn;
   logic        data_ready, tbre, tsre;

   int n_checks = 0;
   int n_fail   = 0;

   uart_ctrl #(.RD_LOW_CYC(2), .WR_LOW_CYC(2)) dut (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .req       (req),
      .op        (op),
      .sel       (sel),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .stall     (stall),
      .bus_i     (bus_i),
      .bus_o     (bus_o),
      .bus_oe    (bus_oe),
      .rdn       (rdn),
      .wrn       (wrn),
      .data_ready(data_ready),
      .tbre      (tbre),
      .tsre      (tsre)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_50MHz);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; op = 1'b0; sel = 1'b0; wdata = '0; bus_i = '0;
      data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
      #5;
      chk("rst_rdn", 16'(rdn), 16'h1);
      chk("rst_wrn", 16'(wrn), 16'h1);
      chk("rst_oe", 16'(bus_oe), 16'h0);
      chk("rst_bus_o", 16'(bus_o), 16'h0);
      chk("rst_rdata", rdata, 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      step(); step();
      rst = 1'b0;
      step(); step(); step();

      // Status read: data_ready=tbre=tsre=1 -> 0x0003 one cycle after accept
      req = 1'b1; op = 1'b0; sel = 1'b1;
      #1 chk("sr_stall_accept", 16'(stall), 16'h1);
      step();
      chk("sr_done", 16'(done), 16'h1);
      chk("sr_rdata", rdata, 16'h0003);
      chk("sr_rdn", 16'(rdn), 16'h1);
      chk("sr_wrn", 16'(wrn), 16'h1);
      chk("sr_stall_done", 16'(stall), 16'h0);
      req = 1'b0;
      step();
      chk("sr_done_clr", 16'(done), 16'h0);

      // Back-to-back status reads with req held: done pulses two cycles apart
      req = 1'b1;
      step(); chk("b2b_done1", 16'(done), 16'h1);
      step(); chk("b2b_gap", 16'(done), 16'h0);
      step(); chk("b2b_done2", 16'(done), 16'h1);
      req = 1'b0;
      step(); chk("b2b_end", 16'(done), 16'h0);

      // Status write: immediate completion, no strobe, rdata 0
      req = 1'b1; op = 1'b1; sel = 1'b1;
      step();
      chk("sw_done", 16'(done), 16'h1);
      chk("sw_rdata", rdata, 16'h0);
      chk("sw_wrn", 16'(wrn), 16'h1);
      chk("sw_oe", 16'(bus_oe), 16'h0);
      req = 1'b0;
      step();

      // Data read with a byte waiting: rdn low two cycles, then done with 0x00A5
      bus_i = 8'hA5;
      req = 1'b1; op = 1'b0; sel = 1'b0;
      step();
      chk("dr_rdn_c1", 16'(rdn), 16'h0);
      chk("dr_done_c1", 16'(done), 16'h0);
      chk("dr_stall_c1", 16'(stall), 16'h1);
      step();
      chk("dr_rdn_c2", 16'(rdn), 16'h0);
      chk("dr_wrn_c2", 16'(wrn), 16'h1);
      step();
      chk("dr_rdn_rel", 16'(rdn), 16'h1);
      chk("dr_done", 16'(done), 16'h1);
      chk("dr_rdata", rdata, 16'h00A5);
      req = 1'b0;
      step();

      // Data read with nothing waiting: immediate done, rdata 0, no rdn pulse
      data_ready = 1'b0;
      step(); step(); step();
      req = 1'b1; op = 1'b0; sel = 1'b0;
      #1 chk("dn_stall_accept", 16'(stall), 16'h1);
      step();
      chk("dn_done", 16'(done), 16'h1);
      chk("dn_rdata", rdata, 16'h0);
      chk("dn_rdn", 16'(rdn), 16'h1);
      chk("dn_stall_done", 16'(stall), 16'h0);
      req = 1'b0;
      step();
      chk("dn_stall_after", 16'(stall), 16'h0);

      // Data write with TX busy; req dropped after accept must not abort it
      tbre = 1'b0; tsre = 1'b0;
      step(); step(); step();
      wdata = 16'h1234;
      req = 1'b1; op = 1'b1; sel = 1'b0;
      step();
      req = 1'b0;
      chk("wr_setup_oe", 16'(bus_oe), 16'h1);
      chk("wr_setup_bus", 16'(bus_o), 16'h0034);
      chk("wr_setup_wrn", 16'(wrn), 16'h1);
      step();
      chk("wr_low1_wrn", 16'(wrn), 16'h0);
      chk("wr_low1_oe", 16'(bus_oe), 16'h1);
      chk("wr_low1_rdn", 16'(rdn), 16'h1);
      step();
      chk("wr_low2_wrn", 16'(wrn), 16'h0);
      chk("wr_low2_bus", 16'(bus_o), 16'h0034);
      step();
      chk("wr_hold_wrn", 16'(wrn), 16'h1);
      chk("wr_hold_oe", 16'(bus_oe), 16'h1);
      step();
      chk("wr_wait_oe", 16'(bus_oe), 16'h0);
      chk("wr_wait_done", 16'(done), 16'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wr_wait_idle", 16'(done), 16'h0);
      end
      tbre = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wr_wait_tbre_only", 16'(done), 16'h0);
      end
      tsre = 1'b1;
      step(); chk("wr_tsre_sync1", 16'(done), 16'h0);
      step(); chk("wr_tsre_sync2", 16'(done), 16'h0);
      step(); chk("wr_done", 16'(done), 16'h1);
      step(); chk("wr_done_clr", 16'(done), 16'h0);

      // Reset pulsed during the write strobe aborts immediately
      wdata = 16'h00C3;
      req = 1'b1; op = 1'b1; sel = 1'b0;
      step();
      req = 1'b0;
      step();
      chk("rw_wrn_low", 16'(wrn), 16'h0);
      #2 rst = 1'b1;
      #1;
      chk("rw_async_wrn", 16'(wrn), 16'h1);
      chk("rw_async_oe", 16'(bus_oe), 16'h0);
      chk("rw_async_bus", 16'(bus_o), 16'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rw_no_done", 16'(done), 16'h0);
         chk("rw_no_wrn", 16'(wrn), 16'h1);
         chk("rw_no_oe", 16'(bus_oe), 16'h0);
      end

      // Status read after the aborted write: data_ready=0, TX idle -> 0x0001
      req = 1'b1; op = 1'b0; sel = 1'b1;
      step();
      chk("rw_sr_done", 16'(done), 16'h1);
      chk("rw_sr_rdata", rdata, 16'h0001);
      req = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
